sparc_ctrl_fsm: RTL and testbench
=================================

// Module: sparc_ctrl_fsm
// PURPOSE
//  Control unit for DataPathV5. Consumes IR and MFC from the datapath and emits every control line
//  that dp5Tester currently drives by hand. Moore FSM covering the reset sequence, fetch, decode,
//  format-3 ALU op, nPC update, Bicc branch (annul aware) and illegal-instruction trap.
//  Sits directly upstream of the datapath; cond_true comes from the condition evaluator.
// PARAMETERS
//  MFC_TIMEOUT  16  max cycles waited in FETCH1 for MFC (used only with CTRL_MFC_TIMEOUT_EN)
// PORTS
//  Clk         in   1   system clock, rising edge
//  Reset       in   1   synchronous, active-high
//  IR          in   32  instruction register contents
//  MFC         in   1   memory function complete
//  cond_true   in   1   Bicc condition result for IR[28:25]
//  ClrAll      out  1   active-low; drives ClrPC/nPCClr/IRClr/tQClr
//  IRE,MDRE,MARE,PCE,nPCE,TBRE,PSRE,WIME,RFE,tQE  out 1 each  active-low register enables
//  nPC_ADD,nPC_ADDSEL,MFA,MOP_SEL,ALUE,BAUX,RA_SEL,AOP_SEL,DISP_SEL  out 1 each  datapath controls
//  nPC_SEL,MAR_SEL,MDR_SEL,ALU_SEL,CIN_SEL,RC_SEL  out 2 each  datapath mux selects
//  state       out  5   current state code (debug)
// BEHAVIOUR
//  - Reset high at a rising edge: state <= RST0 on that edge, aborting any state including a FETCH1
//    wait. MFA deasserts the cycle after the edge. Annul flag and timeout counter clear.
//  - Outputs are decoded from state only. Default values, which are also the reset values:
//    active-low enables and ClrAll = 1; MFA, ALUE, BAUX, nPC_ADD = 0; every select = 0.
//  - States, codes and outputs (only non-default outputs are listed):
//    RST0=0  ClrAll=0                                          -> RST1
//    RST1=1  TBRE=PSRE=WIME=0                                  -> RST2
//    RST2=2  nPCE=0, nPC_ADD=1 (nPC<=PC+4)                     -> FETCH0
//    FETCH0=3  MAR_SEL=1, MARE=0 (MAR<=PC)                     -> FETCH1
//    FETCH1=4  MOP_SEL=1, MDR_SEL=0, MFA=1, MDRE=0; holds while MFC=0 -> FETCH2 when MFC=1
//    FETCH2=5  IRE=0 (IR<=MDR)                                 -> DECODE
//    DECODE=6  no outputs. Next state:
//      IR[31:30]=10 -> ALU0
//      IR[31:30]=00 and IR[24:22]=010 -> BR0
//      anything else -> TRAP0
//    ALU0=7   CIN_SEL=2, ALUE=1 (PSR icc update)               -> ALU1
//    ALU1=8   CIN_SEL=2, RFE=0 (rd<=ALU)                       -> NPC0
//    NPC0=9   PCE=0 (PC<=nPC)                                  -> NPC1
//    NPC1=10  nPCE=0, nPC_ADD=1 (nPC<=nPC+4). Next: if annul=1 then clear annul, -> NPC0; else -> FETCH0
//    BR0=11   PCE=0 (PC<=nPC). Next:
//      cond_true=1 -> BRT
//      cond_true=0 and IR[29]=1 -> NPC1 with annul set
//      cond_true=0 and IR[29]=0 -> NPC1
//    BRT=12   nPC_SEL=2, DISP_SEL=0, BAUX=1, nPCE=0 (nPC<=PC+4*sext(disp22)) -> FETCH0
//    TRAP0=13 tQE=0 (latch trap type)                          -> TRAP1
//    TRAP1=14 PSRE=0, RC_SEL=2, RFE=0 (save PC, supervisor)    -> TRAP2
//    TRAP2=15 TBRE=0, nPC_SEL=1, nPCE=0 (nPC<=TBR)             -> NPC0
//  - Codes 16-31 are unused; any unused code goes to RST0 on the next edge.
//  - Latency: ALU instruction is 9 cycles FETCH0->FETCH0 with MFC one cycle after MFA. Taken branch is 7.
//    Untaken branch is 7, or 9 when annulled.
//  - MFC already high on entry to FETCH1 gives a single FETCH1 cycle. MFC is ignored in all other states.
// CONFIGURATION
//  CTRL_MFC_TIMEOUT_EN defined:
//    - 5-bit counter clears on FETCH1 entry and increments each FETCH1 cycle with MFC=0.
//    - When the counter reaches MFC_TIMEOUT -> TRAP0, with MFA dropping the next cycle.
//  CTRL_MFC_TIMEOUT_EN undefined:
//    - No counter; FETCH1 waits indefinitely for MFC.
// TESTING
//  1. Reset=1 for 2 cycles then 0 -> state 0,1,2,3; ClrAll=0 only in RST0; nPCE=0 with nPC_ADD=1 in RST2.
//  2. IR=32'hA2044012, MFC 1 cycle after MFA -> DECODE->ALU0->ALU1->NPC0->NPC1->FETCH0; ALUE=1 then RFE=0.
//  3. IR=32'h3C800005, cond_true=1 -> BR0->BRT; BRT shows nPC_SEL=2, BAUX=1, nPCE=0; next state FETCH0.
//  4. IR=32'h3C800005, cond_true=0 -> BR0,NPC1,NPC0,NPC1,FETCH0 (annul: nPC advanced twice).
//  5. IR=32'h00000000 -> TRAP0->TRAP1->TRAP2->NPC0; tQE=0 in TRAP0; TBRE=0 and nPC_SEL=1 in TRAP2.
//  6. Reset asserted in FETCH1 with MFC=0 -> RST0 next edge, MFA=0. With macro, MFC held 0 -> TRAP0 after 16 cycles.

Source files
------------

// File: rtl/sparc_ctrl_fsm.sv
// Moore control FSM for DataPathV5: reset sequence, fetch, decode, ALU, nPC update, Bicc, trap.
// Optional FETCH1 MFC timeout to TRAP0 is built when CTRL_MFC_TIMEOUT_EN is defined.
module sparc_ctrl_fsm #(
  parameter int MFC_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic        cond_true,
  output logic        ClrAll,
  output logic        IRE,
  output logic        MDRE,
  output logic        MARE,
  output logic        PCE,
  output logic        nPCE,
  output logic        TBRE,
  output logic        PSRE,
  output logic        WIME,
  output logic        RFE,
  output logic        tQE,
  output logic        nPC_ADD,
  output logic        nPC_ADDSEL,
  output logic        MFA,
  output logic        MOP_SEL,
  output logic        ALUE,
  output logic        BAUX,
  output logic        RA_SEL,
  output logic        AOP_SEL,
  output logic        DISP_SEL,
  output logic [1:0]  nPC_SEL,
  output logic [1:0]  MAR_SEL,
  output logic [1:0]  MDR_SEL,
  output logic [1:0]  ALU_SEL,
  output logic [1:0]  CIN_SEL,
  output logic [1:0]  RC_SEL,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    RST0   = 5'd0,
    RST1   = 5'd1,
    RST2   = 5'd2,
    FETCH0 = 5'd3,
    FETCH1 = 5'd4,
    FETCH2 = 5'd5,
    DECODE = 5'd6,
    ALU0   = 5'd7,
    ALU1   = 5'd8,
    NPC0   = 5'd9,
    NPC1   = 5'd10,
    BR0    = 5'd11,
    BRT    = 5'd12,
    TRAP0  = 5'd13,
    TRAP1  = 5'd14,
    TRAP2  = 5'd15
  } state_t;

  state_t state_q, state_d;
  logic   annul_q, annul_d;
  logic   timeout;

  // Opcode fields not needed for sequencing (cond and disp go straight to the datapath).
  logic unused_ir;
  assign unused_ir = ^{IR[28:25], IR[21:0]};

`ifdef CTRL_MFC_TIMEOUT_EN
  localparam logic [4:0] TIMEOUT_CNT = 5'(MFC_TIMEOUT);
  logic [4:0] wait_cnt_q;

  // Counter sits at zero outside FETCH1, so every FETCH1 entry starts a fresh count.
  always_ff @(posedge Clk) begin
    if (Reset || state_q != FETCH1) begin
      wait_cnt_q <= 5'd0;
    end else if (!MFC) begin
      wait_cnt_q <= wait_cnt_q + 5'd1;
    end
  end

  assign timeout = (state_q == FETCH1) && !MFC && (wait_cnt_q + 5'd1 == TIMEOUT_CNT);
`else
  logic unused_timeout;
  assign unused_timeout = ^MFC_TIMEOUT;
  assign timeout        = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RST0;
      annul_q <= 1'b0;
    end else begin
      state_q <= state_d;
      annul_q <= annul_d;
    end
  end

  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_d = RST0;
    annul_d = annul_q;
    unique case (state_q)
      RST0:   state_d = RST1;
      RST1:   state_d = RST2;
      RST2:   state_d = FETCH0;
      FETCH0: state_d = FETCH1;
      FETCH1: begin
        if (MFC)          state_d = FETCH2;
        else if (timeout) state_d = TRAP0;
        else              state_d = FETCH1;
      end
      FETCH2: state_d = DECODE;
      DECODE: begin
        if (IR[31:30] == 2'b10)                             state_d = ALU0;
        else if (IR[31:30] == 2'b00 && IR[24:22] == 3'b010) state_d = BR0;
        else                                                state_d = TRAP0;
      end
      ALU0:   state_d = ALU1;
      ALU1:   state_d = NPC0;
      NPC0:   state_d = NPC1;
      NPC1: begin
        // An annulled delay slot is skipped by advancing PC/nPC one extra time.
        if (annul_q) begin
          annul_d = 1'b0;
          state_d = NPC0;
        end else begin
          state_d = FETCH0;
        end
      end
      BR0: begin
        if (cond_true) begin
          state_d = BRT;
        end else begin
          state_d = NPC1;
          if (IR[29]) annul_d = 1'b1;
        end
      end
      BRT:    state_d = FETCH0;
      TRAP0:  state_d = TRAP1;
      TRAP1:  state_d = TRAP2;
      TRAP2:  state_d = NPC0;
      default: state_d = RST0;
    endcase
  end

  always_comb begin
    ClrAll     = 1'b1;
    IRE        = 1'b1;
    MDRE       = 1'b1;
    MARE       = 1'b1;
    PCE        = 1'b1;
    nPCE       = 1'b1;
    TBRE       = 1'b1;
    PSRE       = 1'b1;
    WIME       = 1'b1;
    RFE        = 1'b1;
    tQE        = 1'b1;
    nPC_ADD    = 1'b0;
    nPC_ADDSEL = 1'b0;
    MFA        = 1'b0;
    MOP_SEL    = 1'b0;
    ALUE       = 1'b0;
    BAUX       = 1'b0;
    RA_SEL     = 1'b0;
    AOP_SEL    = 1'b0;
    DISP_SEL   = 1'b0;
    nPC_SEL    = 2'd0;
    MAR_SEL    = 2'd0;
    MDR_SEL    = 2'd0;
    ALU_SEL    = 2'd0;
    CIN_SEL    = 2'd0;
    RC_SEL     = 2'd0;
    case (state_q)
      RST0:   ClrAll = 1'b0;
      RST1:   begin TBRE = 1'b0; PSRE = 1'b0; WIME = 1'b0; end
      RST2:   begin nPCE = 1'b0; nPC_ADD = 1'b1; end
      FETCH0: begin MAR_SEL = 2'd1; MARE = 1'b0; end
      FETCH1: begin MOP_SEL = 1'b1; MDR_SEL = 2'd0; MFA = 1'b1; MDRE = 1'b0; end
      FETCH2: IRE = 1'b0;
      ALU0:   begin CIN_SEL = 2'd2; ALUE = 1'b1; end
      ALU1:   begin CIN_SEL = 2'd2; RFE = 1'b0; end
      NPC0:   PCE = 1'b0;
      NPC1:   begin nPCE = 1'b0; nPC_ADD = 1'b1; end
      BR0:    PCE = 1'b0;
      BRT:    begin nPC_SEL = 2'd2; DISP_SEL = 1'b0; BAUX = 1'b1; nPCE = 1'b0; end
      TRAP0:  tQE = 1'b0;
      TRAP1:  begin PSRE = 1'b0; RC_SEL = 2'd2; RFE = 1'b0; end
      TRAP2:  begin TBRE = 1'b0; nPC_SEL = 2'd1; nPCE = 1'b0; end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_sparc_ctrl_fsm.sv
// Directed bench for sparc_ctrl_fsm: vector table of {inputs, expected state} plus FETCH1 wait sequences.
// Covers both builds; the timeout sequence follows CTRL_MFC_TIMEOUT_EN.
module tb_sparc_ctrl_fsm;

  logic        Clk = 1'b0;
  logic        Reset, MFC, cond_true;
  logic [31:0] IR;
  logic        ClrAll, IRE, MDRE, MARE, PCE, nPCE, TBRE, PSRE, WIME, RFE, tQE;
  logic        nPC_ADD, nPC_ADDSEL, MFA, MOP_SEL, ALUE, BAUX, RA_SEL, AOP_SEL, DISP_SEL;
  logic [1:0]  nPC_SEL, MAR_SEL, MDR_SEL, ALU_SEL, CIN_SEL, RC_SEL;
  logic [4:0]  state;

  always #5 Clk = ~Clk;

  sparc_ctrl_fsm dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .MFC(MFC), .cond_true(cond_true),
    .ClrAll(ClrAll), .IRE(IRE), .MDRE(MDRE), .MARE(MARE), .PCE(PCE), .nPCE(nPCE),
    .TBRE(TBRE), .PSRE(PSRE), .WIME(WIME), .RFE(RFE), .tQE(tQE),
    .nPC_ADD(nPC_ADD), .nPC_ADDSEL(nPC_ADDSEL), .MFA(MFA), .MOP_SEL(MOP_SEL),
    .ALUE(ALUE), .BAUX(BAUX), .RA_SEL(RA_SEL), .AOP_SEL(AOP_SEL), .DISP_SEL(DISP_SEL),
    .nPC_SEL(nPC_SEL), .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL), .ALU_SEL(ALU_SEL),
    .CIN_SEL(CIN_SEL), .RC_SEL(RC_SEL), .state(state)
  );

  localparam logic [31:0] IR_ALU   = 32'hA2044012;
  localparam logic [31:0] IR_BRA   = 32'h3C800005;  // Bicc, a=1
  localparam logic [31:0] IR_BRN   = 32'h1C800005;  // Bicc, a=0
  localparam logic [31:0] IR_UNIMP = 32'h00000000;
  localparam logic [31:0] IR_CALL  = 32'h40000000;
  localparam logic [31:0] IR_SETHI = 32'h01000000;

  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic        mfc;
    logic        ct;
    logic [4:0]  exp_state;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] act_ctl;
  assign act_ctl = {ClrAll, IRE, MDRE, MARE, PCE, nPCE, TBRE, PSRE, WIME, RFE, tQE,
                    nPC_ADD, nPC_ADDSEL, MFA, MOP_SEL, ALUE, BAUX, RA_SEL, AOP_SEL, DISP_SEL,
                    nPC_SEL, MAR_SEL, MDR_SEL, ALU_SEL, CIN_SEL, RC_SEL};

  // Expected control word for each state, transcribed from the state/output table.
  function automatic logic [31:0] model_ctl(input logic [4:0] s);
    logic clr, ire, mdre, mare, pce, npce, tbre, psre, wime, rfe, tqe;
    logic npc_add, mfa, mop_sel, alue, baux;
    logic [1:0] npc_sel, mar_sel, cin_sel, rc_sel;
    {clr, ire, mdre, mare, pce, npce, tbre, psre, wime, rfe, tqe} = 11'h7FF;
    {npc_add, mfa, mop_sel, alue, baux} = 5'b0;
    {npc_sel, mar_sel, cin_sel, rc_sel} = 8'b0;
    case (s)
      5'd0:  clr = 1'b0;
      5'd1:  begin tbre = 1'b0; psre = 1'b0; wime = 1'b0; end
      5'd2:  begin npce = 1'b0; npc_add = 1'b1; end
      5'd3:  begin mar_sel = 2'd1; mare = 1'b0; end
      5'd4:  begin mop_sel = 1'b1; mfa = 1'b1; mdre = 1'b0; end
      5'd5:  ire = 1'b0;
      5'd7:  begin cin_sel = 2'd2; alue = 1'b1; end
      5'd8:  begin cin_sel = 2'd2; rfe = 1'b0; end
      5'd9:  pce = 1'b0;
      5'd10: begin npce = 1'b0; npc_add = 1'b1; end
      5'd11: pce = 1'b0;
      5'd12: begin npc_sel = 2'd2; baux = 1'b1; npce = 1'b0; end
      5'd13: tqe = 1'b0;
      5'd14: begin psre = 1'b0; rc_sel = 2'd2; rfe = 1'b0; end
      5'd15: begin tbre = 1'b0; npc_sel = 2'd1; npce = 1'b0; end
      default: ;
    endcase
    return {clr, ire, mdre, mare, pce, npce, tbre, psre, wime, rfe, tqe,
            npc_add, 1'b0, mfa, mop_sel, alue, baux, 1'b0, 1'b0, 1'b0,
            npc_sel, mar_sel, 2'd0, 2'd0, cin_sel, rc_sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [31:0] ir, input logic mfc, input logic ct,
                     input logic [4:0] exp_state);
    vec_t v;
    v.rst = rst; v.ir = ir; v.mfc = mfc; v.ct = ct; v.exp_state = exp_state;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic rst, input logic [31:0] ir, input logic mfc, input logic ct);
    Reset = rst; IR = ir; MFC = mfc; cond_true = ct;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_state(input string name, input logic [4:0] exp_state);
    check({name, " state"}, {27'd0, state}, {27'd0, exp_state});
    check({name, " ctl"}, act_ctl, model_ctl(exp_state));
  endtask

  initial begin
    Reset = 1'b1; IR = 32'd0; MFC = 1'b0; cond_true = 1'b0;

    // Reset sequence
    add(1, 0, 0, 0, 0);  add(1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1);  add(0, 0, 0, 0, 2);  add(0, 0, 0, 0, 3);
    // ALU op, MFC one cycle after MFA: 9 cycles FETCH0 -> FETCH0
    add(0, IR_ALU, 0, 0, 4);  add(0, IR_ALU, 0, 0, 4);  add(0, IR_ALU, 1, 0, 5);
    add(0, IR_ALU, 0, 0, 6);  add(0, IR_ALU, 0, 0, 7);  add(0, IR_ALU, 0, 0, 8);
    add(0, IR_ALU, 0, 0, 9);  add(0, IR_ALU, 0, 0, 10); add(0, IR_ALU, 0, 0, 3);
    // Taken branch; MFC high outside FETCH1 must be ignored
    add(0, IR_BRA, 0, 1, 4);  add(0, IR_BRA, 0, 1, 4);  add(0, IR_BRA, 1, 1, 5);
    add(0, IR_BRA, 1, 1, 6);  add(0, IR_BRA, 1, 1, 11); add(0, IR_BRA, 1, 1, 12);
    add(0, IR_BRA, 1, 1, 3);
    // Untaken annulled branch, MFC already high on FETCH1 entry
    add(0, IR_BRA, 1, 0, 4);  add(0, IR_BRA, 1, 0, 5);  add(0, IR_BRA, 0, 0, 6);
    add(0, IR_BRA, 0, 0, 11); add(0, IR_BRA, 0, 0, 10); add(0, IR_BRA, 0, 0, 9);
    add(0, IR_BRA, 0, 0, 10); add(0, IR_BRA, 0, 0, 3);
    // ALU again: annul must have cleared, so NPC1 -> FETCH0
    add(0, IR_ALU, 1, 0, 4);  add(0, IR_ALU, 1, 0, 5);  add(0, IR_ALU, 0, 0, 6);
    add(0, IR_ALU, 0, 0, 7);  add(0, IR_ALU, 0, 0, 8);  add(0, IR_ALU, 0, 0, 9);
    add(0, IR_ALU, 0, 0, 10); add(0, IR_ALU, 0, 0, 3);
    // Untaken, not annulled
    add(0, IR_BRN, 1, 0, 4);  add(0, IR_BRN, 1, 0, 5);  add(0, IR_BRN, 0, 0, 6);
    add(0, IR_BRN, 0, 0, 11); add(0, IR_BRN, 0, 0, 10); add(0, IR_BRN, 0, 0, 3);
    // Illegal: unimp, call, sethi all trap
    add(0, IR_UNIMP, 1, 0, 4); add(0, IR_UNIMP, 1, 0, 5); add(0, IR_UNIMP, 0, 0, 6);
    add(0, IR_UNIMP, 0, 0, 13); add(0, IR_UNIMP, 0, 0, 14); add(0, IR_UNIMP, 0, 0, 15);
    add(0, IR_UNIMP, 0, 0, 9);  add(0, IR_UNIMP, 0, 0, 10); add(0, IR_UNIMP, 0, 0, 3);
    add(0, IR_CALL, 1, 0, 4);  add(0, IR_CALL, 1, 0, 5);  add(0, IR_CALL, 0, 0, 6);
    add(0, IR_CALL, 0, 0, 13);
    add(0, IR_CALL, 0, 0, 14); add(0, IR_CALL, 0, 0, 15); add(0, IR_CALL, 0, 0, 9);
    add(0, IR_CALL, 0, 0, 10); add(0, IR_CALL, 0, 0, 3);
    add(0, IR_SETHI, 1, 0, 4); add(0, IR_SETHI, 1, 0, 5); add(0, IR_SETHI, 0, 0, 6);
    add(0, IR_SETHI, 0, 0, 13);
    add(0, IR_SETHI, 0, 0, 14); add(0, IR_SETHI, 0, 0, 15); add(0, IR_SETHI, 0, 0, 9);
    add(0, IR_SETHI, 0, 0, 10); add(0, IR_SETHI, 0, 0, 3);
    // Reset while annul is pending must clear it
    add(0, IR_BRA, 1, 0, 4);  add(0, IR_BRA, 1, 0, 5);  add(0, IR_BRA, 0, 0, 6);
    add(0, IR_BRA, 0, 0, 11); add(0, IR_BRA, 0, 0, 10);
    add(1, IR_BRA, 0, 0, 0);  add(0, IR_BRA, 0, 0, 1);  add(0, IR_BRA, 0, 0, 2);
    add(0, IR_BRA, 0, 0, 3);
    add(0, IR_ALU, 1, 0, 4);  add(0, IR_ALU, 1, 0, 5);  add(0, IR_ALU, 0, 0, 6);
    add(0, IR_ALU, 0, 0, 7);  add(0, IR_ALU, 0, 0, 8);  add(0, IR_ALU, 0, 0, 9);
    add(0, IR_ALU, 0, 0, 10); add(0, IR_ALU, 0, 0, 3);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].ir, vecs[i].mfc, vecs[i].ct);
      check_state($sformatf("vec%0d", i), vecs[i].exp_state);
    end

    // Reset aborts a FETCH1 wait; MFA drops the cycle after the edge
    step(0, IR_ALU, 0, 0);
    check_state("wait entry", 5'd4);
    for (int i = 0; i < 3; i++) begin
      step(0, IR_ALU, 0, 0);
      check_state($sformatf("wait hold%0d", i), 5'd4);
    end
    step(1, IR_ALU, 0, 0);
    check_state("wait reset", 5'd0);
    check("wait reset MFA", {31'd0, MFA}, 32'd0);
    step(0, IR_ALU, 0, 0); step(0, IR_ALU, 0, 0); step(0, IR_ALU, 0, 0);
    check_state("post reset", 5'd3);

    step(0, IR_ALU, 0, 0);
    check_state("long wait entry", 5'd4);
`ifdef CTRL_MFC_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      step(0, IR_ALU, 0, 0);
      check_state($sformatf("timeout cyc%0d", i), (i < 16) ? 5'd4 : 5'd13);
    end
    check("timeout MFA", {31'd0, MFA}, 32'd0);
    step(0, IR_ALU, 0, 0);
    check_state("timeout trap1", 5'd14);
`else
    for (int i = 1; i <= 40; i++) begin
      step(0, IR_ALU, 0, 0);
      check_state($sformatf("no timeout cyc%0d", i), 5'd4);
    end
    step(0, IR_ALU, 1, 0);
    check_state("late MFC", 5'd5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
